// File: rtl/alu_op_sequencer.sv
// Step-button driven sequencer for a shared ALU: latches operands on a press,
// waits out the ALU latency, captures the result/flags and drives an LED byte.
module alu_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 3,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic [OP_W-1:0]   op_sel,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [OP_W-1:0]   alu_OP,
    input  logic [DATA_W-1:0] alu_F,
    input  logic              alu_ZF,
    input  logic              alu_OF,
    output logic [DATA_W-1:0] fout,
    output logic              zf,
    output logic              of,
    output logic              busy,
    output logic              done,
    output logic [7:0]        op_count,
    input  logic [2:0]        disp_sel,
    output logic [7:0]        disp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(ALU_LAT);

    state_t     state_reg;
    logic [3:0] wcnt_reg;
    logic       sync1_reg;
    logic       sync2_reg;
    logic       stp_edge;
    logic [7:0] disp_next;
    logic [7:0] fout_byte [4];

    assign stp_edge = sync1_reg & ~sync2_reg;

    // Byte lanes beyond the configured data width read as zero on the LEDs.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            if (8 * gi < DATA_W) begin : g_live
                assign fout_byte[gi] = fout[8*gi +: 8];
            end else begin : g_pad
                assign fout_byte[gi] = 8'h00;
            end
        end
    endgenerate

    // Sync flops reset high so a button held through reset release does not fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            state_reg <= IDLE;
            wcnt_reg  <= 4'd0;
            alu_A     <= '0;
            alu_B     <= '0;
            alu_OP    <= '0;
            fout      <= '0;
            zf        <= 1'b0;
            of        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            op_count  <= 8'd0;
        end else begin
            sync1_reg <= step;
            sync2_reg <= sync1_reg;
            done      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (stp_edge) begin
                        alu_A     <= a_in;
                        alu_B     <= b_in;
                        alu_OP    <= op_sel;
                        wcnt_reg  <= 4'd0;
                        busy      <= 1'b1;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    // The edge that sees the full latency elapsed is the capture edge.
                    if (wcnt_reg == LAT_CNT) begin
                        fout      <= alu_F;
                        zf        <= alu_ZF;
                        of        <= alu_OF;
                        op_count  <= op_count + 8'd1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= CAPTURE;
                    end else begin
                        wcnt_reg <= wcnt_reg + 4'd1;
                    end
                end
                CAPTURE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        disp_next = 8'h00;
        case (disp_sel)
            3'd0: disp_next = fout_byte[0];
            3'd1: disp_next = fout_byte[1];
            3'd2: disp_next = fout_byte[2];
            3'd3: disp_next = fout_byte[3];
            3'd4: disp_next = {6'b0, of, zf};
            3'd5: disp_next = op_count;
            3'd6: disp_next = {5'b0, busy, state_reg};
            3'd7: disp_next = 8'h00;
            default: disp_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp <= 8'h00;
        end else begin
            disp <= disp_next;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a one-cycle-latency stand-in ALU.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic [2:0]  op_sel;
    logic [31:0] a_in, b_in;
    logic [31:0] alu_A, alu_B;
    logic [2:0]  alu_OP;
    logic [31:0] alu_F;
    logic        alu_ZF, alu_OF;
    logic [31:0] fout;
    logic        zf, of, busy, done;
    logic [7:0]  op_count;
    logic [2:0]  disp_sel;
    logic [7:0]  disp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(32), .OP_W(3), .ALU_LAT(1)) dut (
        .clk(clk), .rst(rst), .step(step), .op_sel(op_sel),
        .a_in(a_in), .b_in(b_in),
        .alu_A(alu_A), .alu_B(alu_B), .alu_OP(alu_OP),
        .alu_F(alu_F), .alu_ZF(alu_ZF), .alu_OF(alu_OF),
        .fout(fout), .zf(zf), .of(of), .busy(busy), .done(done),
        .op_count(op_count), .disp_sel(disp_sel), .disp(disp)
    );

    // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; result registered once.
    logic [31:0] f_comb;
    logic        of_comb;
    always_comb begin
        f_comb  = 32'd0;
        of_comb = 1'b0;
        case (alu_OP)
            3'd0: begin
                f_comb  = alu_A + alu_B;
                of_comb = (alu_A[31] == alu_B[31]) && (f_comb[31] != alu_A[31]);
            end
            3'd1: begin
                f_comb  = alu_A - alu_B;
                of_comb = (alu_A[31] != alu_B[31]) && (f_comb[31] != alu_A[31]);
            end
            3'd2: f_comb = alu_A & alu_B;
            3'd3: f_comb = alu_A | alu_B;
            3'd4: f_comb = alu_A ^ alu_B;
            default: f_comb = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        alu_F  <= f_comb;
        alu_ZF <= (f_comb == 32'd0);
        alu_OF <= of_comb;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] f;
        logic        zf;
        logic        of;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One press, then watch 12 cycles counting busy cycles and done pulses.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          output int busy_cyc, output int done_cyc);
        @(negedge clk);
        a_in = a; b_in = b; op_sel = op; step = 1'b1;
        busy_cyc = 0;
        done_cyc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 1) step = 1'b0;
            busy_cyc += int'(busy);
            done_cyc += int'(done);
        end
        $display("op a=%h b=%h op=%0d -> fout=%h zf=%b of=%b cnt=%0d busy_cyc=%0d done_cyc=%0d",
                 a, b, op, fout, zf, of, op_count, busy_cyc, done_cyc);
    endtask

    initial begin
        int bc, dc, done_total;
        logic [7:0]  exp_cnt;
        logic [7:0]  exp_disp;
        logic [31:0] tmp;

        vecs[0] = '{32'h7FFFFFFF, 32'h00000001, 3'd0, 32'h80000000, 1'b0, 1'b1};
        vecs[1] = '{32'h00000005, 32'hFFFFFFFB, 3'd0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h0000000A, 32'h00000003, 3'd1, 32'h00000007, 1'b0, 1'b0};
        vecs[3] = '{32'h80000000, 32'h00000001, 3'd1, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[4] = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'd2, 32'h00F000F0, 1'b0, 1'b0};
        vecs[5] = '{32'h12345678, 32'h12345678, 3'd4, 32'h00000000, 1'b1, 1'b0};
        vecs[6] = '{32'h12000034, 32'h00560000, 3'd3, 32'h12560034, 1'b0, 1'b0};

        // Reset released with the button held high: nothing may start.
        rst = 1'b0; step = 1'b1; op_sel = 3'd0; a_in = 32'd0; b_in = 32'd0; disp_sel = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt", 32'(op_count), 32'd0);
        for (int s = 0; s < 8; s++) begin
            disp_sel = 3'(s);
            @(negedge clk);
            chk($sformatf("rst_disp%0d", s), 32'(disp), 32'd0);
        end
        step = 1'b0;
        repeat (3) @(negedge clk);

        // Table-driven operations with LED byte readback.
        exp_cnt = 8'd0;
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, bc, dc);
            exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("v%0d_fout", i), fout, vecs[i].f);
            chk($sformatf("v%0d_zf", i), 32'(zf), 32'(vecs[i].zf));
            chk($sformatf("v%0d_of", i), 32'(of), 32'(vecs[i].of));
            chk($sformatf("v%0d_busycyc", i), 32'(bc), 32'd2);
            chk($sformatf("v%0d_donecyc", i), 32'(dc), 32'd1);
            chk($sformatf("v%0d_cnt", i), 32'(op_count), 32'(exp_cnt));
            for (int s = 0; s < 6; s++) begin
                tmp = vecs[i].f;
                if (s < 4)       exp_disp = tmp[8*s +: 8];
                else if (s == 4) exp_disp = {6'b0, vecs[i].of, vecs[i].zf};
                else             exp_disp = exp_cnt;
                disp_sel = 3'(s);
                @(negedge clk);
                chk($sformatf("v%0d_disp%0d", i, s), 32'(disp), 32'(exp_disp));
            end
        end

        // Second press while WAIT is in progress must be dropped.
        disp_sel = 3'd6;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dc += int'(done);
            case (i)
                0: begin a_in = 32'd20; b_in = 32'd22; op_sel = 3'd0; step = 1'b1; end
                1: step = 1'b0;
                2: step = 1'b1;
                3: chk("wp_disp_wait", 32'(disp), 32'h05);
                4: step = 1'b0;
                5: chk("wp_disp_capture", 32'(disp), 32'h02);
                default: ;
            endcase
        end
        exp_cnt = exp_cnt + 8'd1;
        $display("op wait-press -> fout=%h cnt=%0d done_cyc=%0d", fout, op_count, dc);
        chk("wp_donecyc", 32'(dc), 32'd1);
        chk("wp_cnt", 32'(op_count), 32'(exp_cnt));
        chk("wp_fout", fout, 32'd42);
        chk("wp_disp_idle", 32'(disp), 32'h00);

        // Reset in the middle of WAIT aborts the operation.
        @(negedge clk);
        a_in = 32'd9; b_in = 32'd0; op_sel = 3'd0; step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        chk("ra_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("ra_fout", fout, 32'd0);
        chk("ra_busy", 32'(busy), 32'd0);
        chk("ra_cnt", 32'(op_count), 32'd0);
        chk("ra_alu_A", alu_A, 32'd0);
        @(negedge clk);
        chk("ra_disp", 32'(disp), 32'd0);
        rst = 1'b1;
        dc = 0;
        repeat (5) begin
            @(negedge clk);
            dc += int'(done);
        end
        $display("op reset-abort -> fout=%h busy=%b cnt=%0d done_cyc=%0d", fout, busy, op_count, dc);
        chk("ra_nodone", 32'(dc), 32'd0);
        chk("ra_fout_after", fout, 32'd0);

        // 256 operations: counter wraps back to zero.
        done_total = 0;
        for (int i = 0; i < 256; i++) begin
            run_op((i == 0) ? 32'd9 : 32'(i), (i == 0) ? 32'd0 : 32'd9, 3'd0, bc, dc);
            done_total += dc;
            if (i == 0)   chk("wrap_first_fout", fout, 32'd9);
            if (i == 254) chk("wrap_cnt_ff", 32'(op_count), 32'hFF);
        end
        chk("wrap_cnt", 32'(op_count), 32'h00);
        chk("wrap_done_total", 32'(done_total), 32'd256);
        chk("wrap_last_fout", fout, 32'd264);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
